buck_pwm_ctrl: RTL and testbench
================================

Name: buck_pwm_ctrl

Overview:
Closed-loop digital PWM controller for the buck converter model: the driving end of the gate interface, replacing the fixed-duty PWM source.
- Samples the fixed-point output voltage and runs a PI law once per switching period.
- Applies soft-start and duty clamping, and drives the registered gate signal.
- Sits between the converter model's v_out output and its gate input in closed-loop testbenches and FPGA emulation.

Parameters:
CNT_WIDTH, 16, width of period counter and duty values
V_WIDTH, 16, width of signed fixed-point voltage inputs (same scale for v_ref and v_meas)
PERIOD, 200, clock cycles per PWM period (2..2^CNT_WIDTH-1)
DUTY_MIN, 0, lower duty clamp in cycles
DUTY_MAX, 180, upper duty clamp in cycles (DUTY_MIN <= DUTY_MAX <= PERIOD)
KP_SHIFT, 2, proportional gain = 2^-KP_SHIFT
KI_SHIFT, 4, integral gain per period = 2^-KI_SHIFT
SS_STEP, 20, soft-start limit increment per period, in cycles (>=1)
DEAD, 4, dead time in cycles (optional feature only)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en  input  1  converter enable; level sensitive
v_ref  input  V_WIDTH  signed voltage setpoint
v_meas  input  V_WIDTH  signed measured v_out
v_valid  input  1  v_meas qualifier; latched when high
gate  output  1  high-side switch drive, registered
duty  output  CNT_WIDTH  duty (cycles) applied in current period
period_start  output  1  one-cycle pulse at counter value 0
sat  output  1  last computed duty was clamped

Behaviour:
- Reset (rst_n=0, asynchronous): gate=0, duty=0, period_start=0, sat=0, cnt=0, integ=DUTY_MIN, ss_lim=DUTY_MIN, v_samp=0, state=IDLE.
- Sample register: v_samp<=v_meas on any cycle with v_valid=1, in every state. The control law uses the most recent latched value.
- States:
  - IDLE: cnt held 0; gate=0; integ=DUTY_MIN; ss_lim=DUTY_MIN. en=1 -> SOFT.
  - SOFT: upper clamp = ss_lim. At each period end, ss_lim += SS_STEP. When the updated ss_lim >= DUTY_MAX, ss_lim=DUTY_MAX and -> RUN.
  - RUN: upper clamp = DUTY_MAX.
  - Any state with en=0 -> IDLE next cycle. gate=0 from that cycle, mid-period included. Re-enable restarts soft-start from DUTY_MIN.
- Counter: in SOFT/RUN, cnt increments and wraps PERIOD-1 -> 0. period_start=1 on the cycle the register shows cnt==0 while in SOFT/RUN.
- Control update, evaluated on the cycle cnt==PERIOD-1:
  - Signed arithmetic in ACC_W = max(CNT_WIDTH,V_WIDTH)+3 bits; shifts are arithmetic.
  - err = v_ref - v_samp.
  - integ_n = clamp(integ + (err>>>KI_SHIFT), DUTY_MIN, upper). This clamp is the anti-windup.
  - d = clamp(integ_n + (err>>>KP_SHIFT), DUTY_MIN, upper).
  - integ, duty and sat are registered together, taking effect with cnt==0. Duty never changes mid-period.
  - sat=1 iff the clamp on d was active.
- Gate: gate register <= (state!=IDLE && en && cnt_next < duty_next). gate is high exactly duty cycles per period, starting at cnt==0.
  - duty=0: gate never rises.
  - duty=PERIOD: gate stays high across the wrap.
- First period after IDLE->SOFT: duty=DUTY_MIN.
- Simultaneous v_valid and update cycle: the update uses the old v_samp; the new sample is used next period.

Optional Feature:
Macro BUCK_PWM_CTRL_SYNC_RECT_EN.
- Defined: adds output port gate_lo (1 bit, registered, reset 0) for a synchronous-rectifier switch.
  - gate_lo=1 iff state!=IDLE and en and duty+DEAD <= cnt < PERIOD-DEAD.
  - gate and gate_lo are never high together, and each is separated from the other by >= DEAD cycles.
  - gate_lo=0 whenever duty+DEAD >= PERIOD-DEAD.
- Undefined: no gate_lo port, no extra logic. The DEAD parameter is unused.

Test Plan:
1. rst_n pulsed low mid-period with gate=1 -> gate, duty, sat, period_start go 0 immediately. With en=0 afterwards, gate stays 0 and period_start never pulses for 1000 cycles.
2. Defaults, en=1, v_ref=1000, v_meas=0 with v_valid=1:
   - Per-period duty: 0,20,40,...,180, then stays 180.
   - State reaches RUN after 9 updates; sat=1 every period from the first update.
3. RUN with integ settled at 90 and v_meas=v_ref=1000 -> duty=90 for 10 consecutive periods, gate high exactly 90 of 200 cycles each period, sat=0.
4. From (3), v_meas steps to 936 (err=+64) mid-period -> duty unchanged until the next wrap, then 90+4+16=110, and the following period 94+4+16=114.
5. en dropped at cnt=50 with duty=90 -> gate=0 on the next cycle. Re-enable gives first duty=0, then the 20,40,... ramp.
6. v_ref=1000, v_meas=4000 in RUN -> duty clamps to 0 at the next wrap, gate low the whole period, sat=1, integ held at DUTY_MIN.
   - With BUCK_PWM_CTRL_SYNC_RECT_EN and duty=90: gate_lo high for cnt 94..195 only.

Source files
------------

// File: rtl/buck_pwm_ctrl.sv
// buck_pwm_ctrl: closed-loop PI PWM controller with soft-start and clamp.
// Optional low-side drive enabled by BUCK_PWM_CTRL_SYNC_RECT_EN.
module buck_pwm_ctrl #(
  parameter int CNT_WIDTH = 16,
  parameter int V_WIDTH   = 16,
  parameter int PERIOD    = 200,
  parameter int DUTY_MIN  = 0,
  parameter int DUTY_MAX  = 180,
  parameter int KP_SHIFT  = 2,
  parameter int KI_SHIFT  = 4,
  parameter int SS_STEP   = 20,
  parameter int DEAD      = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic signed [V_WIDTH-1:0]   v_ref,
  input  logic signed [V_WIDTH-1:0]   v_meas,
  input  logic                        v_valid,
  output logic                        gate,
  output logic        [CNT_WIDTH-1:0] duty,
  output logic                        period_start,
  output logic                        sat
`ifdef BUCK_PWM_CTRL_SYNC_RECT_EN
  ,
  output logic                        gate_lo
`endif
);

  localparam int ACC_W =
    ((CNT_WIDTH > V_WIDTH) ? CNT_WIDTH : V_WIDTH) + 3;
  localparam int ZW = ACC_W - CNT_WIDTH;
  localparam int VW = ACC_W - V_WIDTH;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SOFT = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;

  localparam logic [CNT_WIDTH-1:0] P_LAST =
    CNT_WIDTH'(PERIOD - 1);
  localparam logic [CNT_WIDTH-1:0] D_MIN =
    CNT_WIDTH'(DUTY_MIN);
  localparam logic [CNT_WIDTH-1:0] D_MAX =
    CNT_WIDTH'(DUTY_MAX);
  localparam logic [CNT_WIDTH-1:0] ONE =
    CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH:0] SS_INC =
    (CNT_WIDTH+1)'(SS_STEP);
  localparam logic signed [ACC_W-1:0] LO =
    ACC_W'(DUTY_MIN);

  if (PERIOD < 2 || DUTY_MAX > PERIOD ||
      DUTY_MIN > DUTY_MAX || SS_STEP < 1 ||
      DEAD < 0) begin : g_bad_cfg
    $error("buck_pwm_ctrl: inconsistent parameters");
  end

  logic [1:0]                 state;
  logic [1:0]                 state_nx;
  logic [CNT_WIDTH-1:0]       cnt;
  logic [CNT_WIDTH-1:0]       cnt_nx;
  logic [CNT_WIDTH-1:0]       integ;
  logic [CNT_WIDTH-1:0]       integ_nx;
  logic [CNT_WIDTH-1:0]       ss_lim;
  logic [CNT_WIDTH-1:0]       ss_nx;
  logic [CNT_WIDTH-1:0]       duty_nx;
  logic [CNT_WIDTH-1:0]       ss_new;
  logic [CNT_WIDTH-1:0]       upper;
  logic [CNT_WIDTH-1:0]       i_clip;
  logic [CNT_WIDTH-1:0]       d_clip;
  logic [CNT_WIDTH:0]         ss_sum;
  logic signed [V_WIDTH-1:0]  v_samp;
  logic signed [ACC_W-1:0]    err;
  logic signed [ACC_W-1:0]    i_sum;
  logic signed [ACC_W-1:0]    d_sum;
  logic signed [ACC_W-1:0]    upper_s;
  logic                       upd;
  logic                       ss_done;
  logic                       sat_nx;
  logic                       gate_nx;

  function automatic logic [CNT_WIDTH-1:0] clip(
    input logic signed [ACC_W-1:0] x,
    input logic [CNT_WIDTH-1:0]    hi
  );
    logic signed [ACC_W-1:0] h;
    h = $signed({{ZW{1'b0}}, hi});
    if (x < LO)
      clip = D_MIN;
    else if (x > h)
      clip = hi;
    else
      clip = x[CNT_WIDTH-1:0];
  endfunction

  // Soft-start limit and PI law evaluated for the period-end update.
  always_comb begin
    upd     = (state != IDLE) && en && (cnt == P_LAST);
    ss_sum  = {1'b0, ss_lim} + SS_INC;
    ss_done = (ss_sum >= {1'b0, D_MAX});
    ss_new  = ss_done ? D_MAX : ss_sum[CNT_WIDTH-1:0];
    upper   = (state == SOFT) ? ss_new : D_MAX;
    upper_s = $signed({{ZW{1'b0}}, upper});
    err     = $signed({{VW{v_ref[V_WIDTH-1]}}, v_ref})
            - $signed({{VW{v_samp[V_WIDTH-1]}}, v_samp});
    i_sum   = $signed({{ZW{1'b0}}, integ})
            + (err >>> KI_SHIFT);
    i_clip  = clip(i_sum, upper);
    d_sum   = $signed({{ZW{1'b0}}, i_clip})
            + (err >>> KP_SHIFT);
    d_clip  = clip(d_sum, upper);
  end

  // Next-state, counter and per-period register updates.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    integ_nx = integ;
    ss_nx    = ss_lim;
    duty_nx  = duty;
    sat_nx   = sat;
    if (!en) begin
      state_nx = IDLE;
      cnt_nx   = '0;
      integ_nx = D_MIN;
      ss_nx    = D_MIN;
      duty_nx  = D_MIN;
      sat_nx   = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state_nx = SOFT;
          cnt_nx   = '0;
          integ_nx = D_MIN;
          ss_nx    = D_MIN;
          duty_nx  = D_MIN;
          sat_nx   = 1'b0;
        end
        SOFT, RUN: begin
          cnt_nx = upd ? '0 : cnt + ONE;
          if (upd) begin
            integ_nx = i_clip;
            duty_nx  = d_clip;
            sat_nx   = (d_sum < LO) || (d_sum > upper_s);
            if (state == SOFT) begin
              ss_nx = ss_new;
              if (ss_done)
                state_nx = RUN;
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
    gate_nx = (state_nx != IDLE) && (cnt_nx < duty_nx);
  end

  assign period_start = (state != IDLE) && (cnt == '0);

  // Core state registers; duty/integ/sat only move at the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      integ  <= D_MIN;
      ss_lim <= D_MIN;
      duty   <= '0;
      sat    <= 1'b0;
      gate   <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      integ  <= integ_nx;
      ss_lim <= ss_nx;
      duty   <= duty_nx;
      sat    <= sat_nx;
      gate   <= gate_nx;
    end
  end

  // Latest qualified voltage sample, captured in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      v_samp <= '0;
    else if (v_valid)
      v_samp <= v_meas;
  end

`ifdef BUCK_PWM_CTRL_SYNC_RECT_EN
  localparam logic [CNT_WIDTH:0] DEAD_W =
    (CNT_WIDTH+1)'(DEAD);
  localparam logic [CNT_WIDTH:0] LO_END =
    (CNT_WIDTH+1)'(PERIOD - DEAD);

  logic lo_nx;

  // Low-side window keeps DEAD cycles clear of both gate edges.
  always_comb begin
    lo_nx = (state_nx != IDLE)
         && ({1'b0, duty_nx} + DEAD_W <= {1'b0, cnt_nx})
         && ({1'b0, cnt_nx} < LO_END);
  end

  // Registered low-side drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      gate_lo <= 1'b0;
    else
      gate_lo <= lo_nx;
  end
`endif

endmodule

// File: tb/tb_buck_pwm_ctrl.sv
// tb_buck_pwm_ctrl: bench for buck_pwm_ctrl with a per-period model.
// Builds with or without BUCK_PWM_CTRL_SYNC_RECT_EN.
module tb_buck_pwm_ctrl;

  localparam int PERIOD = 200;
  localparam int DMIN   = 0;
  localparam int DMAX   = 180;
  localparam int KP     = 2;
  localparam int KI     = 4;
  localparam int SS     = 20;
  localparam int DEAD   = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic signed [15:0] v_ref;
  logic signed [15:0] v_meas;
  logic v_valid;
  logic gate;
  logic [15:0] duty;
  logic period_start;
  logic sat;
`ifdef BUCK_PWM_CTRL_SYNC_RECT_EN
  logic gate_lo;
`endif

  int nvec = 0;
  int nerr = 0;

  // model of the controller, one period at a time
  bit m_on, m_soft, m_sat, m_gate, m_ps;
  int m_ph, m_duty, m_integ, m_lim, m_samp;

  always #5 clk = ~clk;

  buck_pwm_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .v_ref(v_ref),
    .v_meas(v_meas),
    .v_valid(v_valid),
    .gate(gate),
    .duty(duty),
    .period_start(period_start),
    .sat(sat)
`ifdef BUCK_PWM_CTRL_SYNC_RECT_EN
    ,
    .gate_lo(gate_lo)
`endif
  );

  function automatic int fdiv(input int x, input int s);
    int d;
    d = 1 << s;
    if (x >= 0) return x / d;
    return -((-x + d - 1) / d);
  endfunction

  function automatic int clampi(input int x, input int lo,
                                input int hi);
    if (x < lo) return lo;
    if (x > hi) return hi;
    return x;
  endfunction

  task automatic model_reset();
    m_on = 0; m_soft = 0; m_sat = 0; m_gate = 0; m_ps = 0;
    m_ph = 0; m_duty = 0; m_integ = DMIN; m_lim = DMIN;
    m_samp = 0;
  endtask

  task automatic model_edge();
    int old, e, ni, d, hi;
    old = m_samp;
    if (v_valid) m_samp = int'(v_meas);
    if (!en) begin
      m_on = 0; m_soft = 0; m_ph = 0; m_duty = DMIN;
      m_sat = 0; m_integ = DMIN; m_lim = DMIN;
    end else if (!m_on) begin
      m_on = 1; m_soft = 1; m_ph = 0; m_duty = DMIN;
    end else if (m_ph == PERIOD - 1) begin
      if (m_soft) begin
        m_lim += SS;
        if (m_lim >= DMAX) begin
          m_lim = DMAX;
          m_soft = 0;
        end
      end
      hi = m_soft ? m_lim : DMAX;
      e = int'(v_ref) - old;
      ni = clampi(m_integ + fdiv(e, KI), DMIN, hi);
      d = ni + fdiv(e, KP);
      m_sat = (d < DMIN) || (d > hi);
      m_duty = clampi(d, DMIN, hi);
      m_integ = ni;
      m_ph = 0;
    end else begin
      m_ph++;
    end
    m_gate = m_on && (m_ph < m_duty);
    m_ps = m_on && (m_ph == 0);
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_to_phase(input int p);
    int n;
    n = 0;
    while (!(m_on && m_ph == p) && n < 3 * PERIOD) begin
      cyc();
      n++;
    end
    if (n >= 3 * PERIOD) begin
      nvec++;
      nerr++;
      $display("FAIL run_to_phase: phase %0d not reached", p);
    end
  endtask

  task automatic goto90();
    v_ref = 16'sd1000;
    v_valid = 1'b1;
    run_to_phase(100);
    v_meas = 16'sd4000;
    run_to_phase(PERIOD - 1);
    cyc();
    run_to_phase(100);
    v_meas = -16'sd440;
    run_to_phase(PERIOD - 1);
    cyc();
    run_to_phase(100);
    v_meas = 16'sd1000;
    run_to_phase(PERIOD - 1);
    cyc();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; v_valid = 1'b0;
    v_ref = '0; v_meas = '0;
    model_reset();
    repeat (3) @(negedge clk);
    nvec++;
    if ({gate, duty, sat, period_start} !== 19'd0) begin
      nerr++;
      $display("FAIL reset_state: g=%b d=%0d s=%b ps=%b want 0",
               gate, duty, sat, period_start);
    end
    rst_n = 1'b1;
    en = 1'b1; v_ref = 16'sd1000; v_meas = '0; v_valid = 1'b1;
    repeat (PERIOD + 5) cyc();
    nvec++;
    if (gate !== 1'b1 || duty !== 16'd20) begin
      nerr++;
      $display("FAIL pre_reset: g=%b d=%0d want 1 20",
               gate, duty);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    nvec++;
    if ({gate, duty, sat, period_start} !== 19'd0) begin
      nerr++;
      $display("FAIL async_reset: g=%b d=%0d s=%b ps=%b want 0",
               gate, duty, sat, period_start);
    end
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b1;
    repeat (1000) begin
      cyc();
      nvec++;
      if (gate !== 1'b0 || period_start !== 1'b0) begin
        nerr++;
        $display("FAIL idle_quiet: g=%b ps=%b want 0 0",
                 gate, period_start);
      end
    end
  endtask

  task automatic test_softstart();
    int k, hi, ex;
    k = -1; hi = 0; ex = 0;
    en = 1'b1; v_ref = 16'sd1000; v_meas = '0; v_valid = 1'b1;
    repeat (12 * PERIOD) begin
      cyc();
      nvec++;
      if (gate !== m_gate || duty !== 16'(m_duty) ||
          sat !== m_sat || period_start !== m_ps) begin
        nerr++;
        $display("FAIL ss_model: g=%b d=%0d s=%b want %b %0d %b",
                 gate, duty, sat, m_gate, m_duty, m_sat);
      end
      if (m_ph == 0) begin
        k++;
        hi = 0;
        ex = (k * SS > DMAX) ? DMAX : k * SS;
        nvec++;
        if (duty !== 16'(ex) || sat !== (k >= 1)) begin
          nerr++;
          $display("FAIL ss_ramp: k=%0d d=%0d s=%b want %0d %b",
                   k, duty, sat, ex, k >= 1);
        end
      end
      if (gate === 1'b1) hi++;
      if (m_ph == PERIOD - 1) begin
        nvec++;
        if (hi != ex) begin
          nerr++;
          $display("FAIL ss_width: k=%0d high=%0d want %0d",
                   k, hi, ex);
        end
      end
    end
  endtask

  task automatic test_clamp_low();
    int hi;
    hi = 0;
    run_to_phase(100);
    v_meas = 16'sd4000;
    run_to_phase(PERIOD - 1);
    repeat (PERIOD) begin
      cyc();
      if (gate === 1'b1) hi++;
      if (m_ph == 0) begin
        nvec++;
        if (duty !== 16'd0 || sat !== 1'b1) begin
          nerr++;
          $display("FAIL clamp_low: d=%0d s=%b want 0 1",
                   duty, sat);
        end
      end
    end
    nvec++;
    if (hi != 0) begin
      nerr++;
      $display("FAIL clamp_gate: high=%0d want 0", hi);
    end
  endtask

  task automatic test_settle();
    goto90();
    for (int p = 0; p < 10; p++) begin
      int hi;
      hi = 0;
      nvec++;
      if (duty !== 16'd90 || sat !== 1'b0 ||
          period_start !== 1'b1) begin
        nerr++;
        $display("FAIL settle: p=%0d d=%0d s=%b ps=%b want 90 0 1",
                 p, duty, sat, period_start);
      end
      for (int c = 0; c < PERIOD; c++) begin
        if (gate === 1'b1) hi++;
`ifdef BUCK_PWM_CTRL_SYNC_RECT_EN
        nvec++;
        if (gate_lo !== (c >= 94 && c <= 195)) begin
          nerr++;
          $display("FAIL gate_lo: c=%0d got %b", c, gate_lo);
        end
`endif
        cyc();
      end
      nvec++;
      if (hi != 90) begin
        nerr++;
        $display("FAIL settle_width: high=%0d want 90", hi);
      end
    end
  endtask

  task automatic test_step();
    run_to_phase(100);
    v_meas = 16'sd936;
    run_to_phase(PERIOD - 1);
    nvec++;
    if (duty !== 16'd90) begin
      nerr++;
      $display("FAIL step_hold: d=%0d want 90", duty);
    end
    cyc();
    nvec++;
    if (duty !== 16'd110 || sat !== 1'b0) begin
      nerr++;
      $display("FAIL step_1: d=%0d s=%b want 110 0", duty, sat);
    end
    run_to_phase(PERIOD - 1);
    cyc();
    nvec++;
    if (duty !== 16'd114) begin
      nerr++;
      $display("FAIL step_2: d=%0d want 114", duty);
    end
    run_to_phase(PERIOD - 1);
    v_meas = 16'sd1000;
    cyc();
    nvec++;
    if (duty !== 16'd118) begin
      nerr++;
      $display("FAIL race_old: d=%0d want 118", duty);
    end
    run_to_phase(PERIOD - 1);
    cyc();
    nvec++;
    if (duty !== 16'd102) begin
      nerr++;
      $display("FAIL race_new: d=%0d want 102", duty);
    end
  endtask

  task automatic test_en_drop();
    int k;
    k = -1;
    goto90();
    run_to_phase(50);
    nvec++;
    if (gate !== 1'b1 || duty !== 16'd90) begin
      nerr++;
      $display("FAIL drop_pre: g=%b d=%0d want 1 90", gate, duty);
    end
    en = 1'b0;
    cyc();
    nvec++;
    if (gate !== 1'b0 || period_start !== 1'b0) begin
      nerr++;
      $display("FAIL drop_gate: g=%b ps=%b want 0 0",
               gate, period_start);
    end
    v_meas = '0;
    repeat (5) cyc();
    en = 1'b1;
    repeat (3 * PERIOD) begin
      cyc();
      if (m_ph == 0) begin
        k++;
        nvec++;
        if (duty !== 16'(k * SS)) begin
          nerr++;
          $display("FAIL reramp: k=%0d d=%0d want %0d",
                   k, duty, k * SS);
        end
      end
    end
  endtask

  task automatic test_random();
    repeat (8 * PERIOD) begin
      int nz;
      en = ($urandom_range(0, 299) != 0);
      v_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0)
        v_ref = 16'($urandom_range(500, 1500));
      nz = int'($urandom_range(0, 1200)) - 600;
      if ($urandom_range(0, 19) == 0)
        v_meas = 16'($urandom_range(0, 65535));
      else
        v_meas = 16'(int'(v_ref) + nz);
      cyc();
      nvec++;
      if (gate !== m_gate || duty !== 16'(m_duty) ||
          sat !== m_sat || period_start !== m_ps) begin
        nerr++;
        $display("FAIL rand: g=%b d=%0d s=%b ps=%b want %b %0d %b %b",
                 gate, duty, sat, period_start,
                 m_gate, m_duty, m_sat, m_ps);
      end
    end
  endtask

  initial begin
    test_reset();
    test_softstart();
    test_clamp_low();
    test_settle();
    test_step();
    test_en_drop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

endmodule
